// File: rtl/game_pkg.sv
// Shared game types and constants: painter state encoding,
// visible screen size and the palette used by the controller.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAINT,
        DONE
    } painter_state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;
    localparam logic [2:0] COL_P1    = 3'b100;
    localparam logic [2:0] COL_P2    = 3'b001;

endpackage

// File: rtl/rect_painter_xy_counter.sv
// Nested column/row offset counter for the rectangle walk.
// col_next/row_next give the offsets that will be held after this edge.
module xy_counter #(
    parameter int CW = 8,
    parameter int RW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] col_max,
    input  logic [RW-1:0] row_max,
    output logic [CW-1:0] col_next,
    output logic [RW-1:0] row_next,
    output logic          last
);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    always_comb begin
        col_next = col;
        row_next = row;
        if (load) begin
            col_next = '0;
            row_next = '0;
        end else if (en) begin
            if (col == col_max) begin
                col_next = '0;
                row_next = row + RW'(1);
            end else begin
                col_next = col + CW'(1);
            end
        end
    end

    assign last = (col == col_max) && (row == row_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= col_next;
            row <= row_next;
        end
    end

endmodule

// File: rtl/rect_painter.sv
// Rectangle / full-screen pixel walker feeding the VGA adapter,
// one pixel per clock, with off-screen pixels suppressed.
module rect_painter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = game_pkg::SCREEN_W,
    parameter int SCREEN_H = game_pkg::SCREEN_H
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                fill_screen,
    input  logic [X_W-1:0]      x_init,
    input  logic [Y_W-1:0]      y_init,
    input  logic [X_W-1:0]      width,
    input  logic [Y_W-1:0]      height,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot
);

    import game_pkg::*;

    painter_state_t state;

    logic [X_W-1:0] x_op, w_op, x_eff, w_eff, x_base;
    logic [Y_W-1:0] y_op, h_op, y_eff, h_eff, y_base;
    logic [X_W-1:0] col_next;
    logic [Y_W-1:0] row_next;
    logic [X_W:0]   x_sum;
    logic [Y_W:0]   y_sum;
    logic           accept, empty, last, cnt_en, visible;

    assign x_eff = fill_screen ? '0 : x_init;
    assign y_eff = fill_screen ? '0 : y_init;
    assign w_eff = fill_screen ? X_W'(SCREEN_W) : width;
    assign h_eff = fill_screen ? Y_W'(SCREEN_H) : height;

    assign accept = (state == IDLE) && start;
    assign empty  = (w_eff == '0) || (h_eff == '0);
    assign cnt_en = (state == PAINT) && !last;

    // In the accept cycle the operand registers are not loaded yet.
    assign x_base = (state == IDLE) ? x_eff : x_op;
    assign y_base = (state == IDLE) ? y_eff : y_op;

    assign x_sum = {1'b0, x_base} + {1'b0, col_next};
    assign y_sum = {1'b0, y_base} + {1'b0, row_next};

    assign visible = (x_sum < (X_W+1)'(SCREEN_W))
                  && (y_sum < (Y_W+1)'(SCREEN_H));

    xy_counter #(
        .CW (X_W),
        .RW (Y_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .en       (cnt_en),
        .col_max  (w_op - X_W'(1)),
        .row_max  (h_op - Y_W'(1)),
        .col_next (col_next),
        .row_next (row_next),
        .last     (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            x_op       <= '0;
            y_op       <= '0;
            w_op       <= '0;
            h_op       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            plot       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    plot <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        x_op <= x_eff;
                        y_op <= y_eff;
                        w_op <= w_eff;
                        h_op <= h_eff;
                        if (empty) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= PAINT;
                            busy       <= 1'b1;
                            plot       <= visible;
                            x_out      <= x_sum[X_W-1:0];
                            y_out      <= y_sum[Y_W-1:0];
                            colour_out <= colour_in;
                        end
                    end
                end
                PAINT: begin
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        plot  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        plot  <= visible;
                        x_out <= x_sum[X_W-1:0];
                        y_out <= y_sum[Y_W-1:0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_painter.sv
// Scoreboard bench for rect_painter: a request model queues
// the expected pixel/done stream, a monitor checks each cycle.
module tb_rect_painter;

    logic       clk = 1'b0;
    logic       reset, start, fill_screen;
    logic [7:0] x_init, width;
    logic [6:0] y_init, height;
    logic [2:0] colour_in;
    logic       busy, done, plot;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;

    rect_painter dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .fill_screen (fill_screen),
        .x_init      (x_init),
        .y_init      (y_init),
        .width       (width),
        .height      (height),
        .colour_in   (colour_in),
        .busy        (busy),
        .done        (done),
        .x_out       (x_out),
        .y_out       (y_out),
        .colour_out  (colour_out),
        .plot        (plot)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit is_done;
        bit plot;
        int x;
        int y;
        int col;
    } ev_t;

    ev_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  plot_cnt = 0;

    // Expected stream for one accepted request, from the pixel rules.
    task automatic push_req(input bit fill, input int x, input int y,
                            input int w, input int h, input int c,
                            input int n, output int done_cyc);
        int ex, ey, ew, eh, k;
        ev_t e;
        ex = fill ? 0 : x;
        ey = fill ? 0 : y;
        ew = fill ? 160 : w;
        eh = fill ? 120 : h;
        k = 0;
        for (int r = 0; r < eh && ew > 0; r++) begin
            for (int q = 0; q < ew; q++) begin
                e.cyc = n + 1 + k;
                e.is_done = 1'b0;
                e.x = ex + q;
                e.y = ey + r;
                e.plot = (e.x < 160) && (e.y < 120);
                e.col = c;
                sb.push_back(e);
                k++;
            end
        end
        e.cyc = n + 1 + k;
        e.is_done = 1'b1;
        e.plot = 1'b0;
        e.x = 0;
        e.y = 0;
        e.col = 0;
        sb.push_back(e);
        done_cyc = e.cyc;
    endtask

    ev_t m_e;
    bit  m_ok;
    always @(negedge clk) begin
        if (!reset) begin
            if (plot) plot_cnt++;
            tests++;
            if (plot && !busy) begin
                fails++;
                $display("FAIL plot_without_busy cyc=%0d plot=%b busy=%b", cyc, plot, busy);
            end
            if (busy || done) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output cyc=%0d busy=%b done=%b plot=%b (none expected)",
                             cyc, busy, done, plot);
                end else begin
                    m_e = sb.pop_front();
                    m_ok = (cyc == m_e.cyc) && (done == m_e.is_done)
                        && (busy == !m_e.is_done) && (plot == m_e.plot)
                        && (!m_e.plot || (int'(x_out) == m_e.x && int'(y_out) == m_e.y
                                          && int'(colour_out) == m_e.col));
                    if (!m_ok) begin
                        fails++;
                        $display("FAIL pixel cyc=%0d busy=%b done=%b plot=%b x=%0d y=%0d c=%0d | want cyc=%0d done=%b plot=%b x=%0d y=%0d c=%0d",
                                 cyc, busy, done, plot, x_out, y_out, colour_out,
                                 m_e.cyc, m_e.is_done, m_e.plot, m_e.x, m_e.y, m_e.col);
                    end
                end
            end
        end
    end

    task automatic issue(input bit fill, input int x, input int y,
                         input int w, input int h, input int c);
        int d;
        @(negedge clk);
        fill_screen = fill;
        x_init = 8'(x);
        y_init = 7'(y);
        width = 8'(w);
        height = 7'(h);
        colour_in = 3'(c);
        start = 1'b1;
        push_req(fill, x, y, w, h, c, cyc, d);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while (sb.size() != 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout left=%0d want 0 after %0d cycles", sb.size(), limit);
            sb.delete();
        end
    endtask

    task automatic check_zero(input string name);
        logic [20:0] v;
        v = {busy, done, plot, x_out, y_out, colour_out};
        tests++;
        if (v != '0) begin
            fails++;
            $display("FAIL %s outputs=%h want 0", name, v);
        end
    endtask

    initial begin
        int d1, d2, n;
        reset = 1'b1;
        start = 1'b0;
        fill_screen = 1'b0;
        x_init = '0;
        y_init = '0;
        width = '0;
        height = '0;
        colour_in = '0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset_state");
        @(negedge clk) reset = 1'b0;

        issue(0, 10, 20, 3, 2, 3'b100);
        drain(50);

        plot_cnt = 0;
        issue(1, 77, 33, 5, 9, 0);
        drain(20000);
        tests++;
        if (plot_cnt != 19200) begin
            fails++;
            $display("FAIL fill_plot_count got %0d want 19200", plot_cnt);
        end

        issue(0, 5, 5, 0, 5, 2);
        drain(10);

        issue(0, 158, 119, 4, 1, 7);
        drain(20);

        issue(0, 250, 10, 12, 2, 5);
        drain(50);

        // Ignored restart, then reset in the middle of the walk.
        issue(0, 30, 40, 3, 2, 3);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        #1 reset = 1'b1;
        sb.delete();
        #1 check_zero("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (6) @(negedge clk);
        issue(0, 30, 40, 3, 2, 5);
        drain(50);

        // Start held high across two paints.
        @(negedge clk);
        fill_screen = 1'b0;
        x_init = 8'd50;
        y_init = 7'd60;
        width = 8'd2;
        height = 7'd2;
        colour_in = 3'd6;
        start = 1'b1;
        n = cyc;
        push_req(0, 50, 60, 2, 2, 6, n, d1);
        push_req(0, 50, 60, 2, 2, 6, d1 + 1, d2);
        repeat (7) @(posedge clk);
        #1 start = 1'b0;
        drain(50);

        repeat (40) begin
            issue(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 12)), int'($urandom_range(0, 8)),
                  int'($urandom_range(0, 7)));
            drain(200);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
